game_switcher: RTL and testbench

//  Parametrised game-selection core for the seven-segment games top level.

---
 rtl/game_pkg.sv | 20 ++
 rtl/game_switcher_show_timer.sv | 33 +++
 rtl/game_switcher.sv | 136 +++++++++++++
 tb/tb_game_switcher.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the game-selection core.
//   BLANK_CODE  : display code that blanks the seven-segment digit
//   state_e     : RUN (normal play) / SHOW (index banner) encodings
//   timer_width : counter width for a given banner length, never below 1
package game_pkg;

    localparam logic [3:0] BLANK_CODE = 4'd12;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_SHOW = 1'b1
    } state_e;

    function automatic int unsigned timer_width(input int unsigned cycles);
        int unsigned w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/game_switcher_show_timer.sv
// Loadable down-counter that times the game-index banner.
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset (count clears to 0)
//   i_load     : load i_load_val this cycle (takes priority over counting)
//   i_load_val : value to load
//   o_zero     : count is zero
module show_timer #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    // Counts down and parks at zero, so it can never wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/game_switcher.sv
// Game-selection core: cycles the active slot with next/prev pulses (wrapping),
// routes button pulses to the active slot only, muxes its value to the display,
// and shows the new slot index for SHOW_CYCLES after every switch.
// Ports:
//   clk, rst_n        : clock / asynchronous active-low reset
//   i_next_pulse      : select next slot
//   i_prev_pulse      : select previous slot
//   i_btn_pulse       : debounced game-button pulses
//   i_game_value      : slot g value at [g*VAL_W +: VAL_W]
//   o_game_btn        : slot g buttons at [g*NUM_BTNS +: NUM_BTNS] (combinational)
//   o_game_enter      : one-hot, one-cycle pulse to the newly selected slot
//   o_select          : active slot index
//   o_show_active     : index banner is being shown
//   o_display_value   : registered value for the seven-segment driver
module game_switcher
    import game_pkg::*;
#(
    parameter int unsigned NUM_GAMES   = 4,
    parameter int unsigned NUM_BTNS    = 7,
    parameter int unsigned VAL_W       = 4,
    parameter int unsigned SHOW_CYCLES = 1000000,
    parameter int unsigned SEL_W       = $clog2(NUM_GAMES)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_next_pulse,
    input  logic                          i_prev_pulse,
    input  logic [NUM_BTNS-1:0]           i_btn_pulse,
    input  logic [NUM_GAMES*VAL_W-1:0]    i_game_value,
    output logic [NUM_GAMES*NUM_BTNS-1:0] o_game_btn,
    output logic [NUM_GAMES-1:0]          o_game_enter,
    output logic [SEL_W-1:0]              o_select,
    output logic                          o_show_active,
    output logic [VAL_W-1:0]              o_display_value
);

    localparam int unsigned TIMER_W = timer_width(SHOW_CYCLES);

    if (NUM_GAMES < 2 || NUM_GAMES > (1 << VAL_W)) begin : g_bad_num_games
        $fatal(1, "game_switcher: NUM_GAMES must be in 2..2**VAL_W");
    end

    state_e                r_state;
    state_e                w_state_next;
    logic [SEL_W-1:0]      r_select;
    logic [SEL_W-1:0]      w_select_next;
    logic [NUM_GAMES-1:0]  r_enter;
    logic [NUM_GAMES-1:0]  w_enter_next;
    logic [VAL_W-1:0]      r_display;
    logic [VAL_W-1:0]      w_display_next;
    logic                  w_switch;
    logic                  w_timer_zero;

    // Both pulses together cancel out.
    assign w_switch = i_next_pulse ^ i_prev_pulse;

    show_timer #(
        .W(TIMER_W)
    ) u_show_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_switch),
        .i_load_val(TIMER_W'(SHOW_CYCLES - 1)),
        .o_zero    (w_timer_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_RUN;
            r_select  <= '0;
            r_enter   <= '0;
            r_display <= VAL_W'(BLANK_CODE);
        end else begin
            r_state   <= w_state_next;
            r_select  <= w_select_next;
            r_enter   <= w_enter_next;
            r_display <= w_display_next;
        end
    end

    always_comb begin
        w_select_next  = r_select;
        w_state_next   = r_state;
        w_enter_next   = '0;
        w_display_next = '0;

        // Explicit wrap so non-power-of-two slot counts work.
        if (w_switch) begin
            if (i_next_pulse) begin
                w_select_next = (r_select == SEL_W'(NUM_GAMES - 1)) ? '0 : r_select + 1'b1;
            end else begin
                w_select_next = (r_select == '0) ? SEL_W'(NUM_GAMES - 1) : r_select - 1'b1;
            end
        end

        unique case (r_state)
            ST_RUN: begin
                if (w_switch) w_state_next = ST_SHOW;
            end
            ST_SHOW: begin
                // A switch during SHOW re-triggers via the timer reload.
                if (w_switch)          w_state_next = ST_SHOW;
                else if (w_timer_zero) w_state_next = ST_RUN;
            end
            default: w_state_next = ST_RUN;
        endcase

        for (int g = 0; g < int'(NUM_GAMES); g++) begin
            if (w_switch && w_select_next == SEL_W'(g)) w_enter_next[g] = 1'b1;
        end

        if (r_state == ST_SHOW) begin
            w_display_next = VAL_W'(r_select);
        end else begin
            for (int g = 0; g < int'(NUM_GAMES); g++) begin
                if (r_select == SEL_W'(g)) w_display_next = i_game_value[g*VAL_W +: VAL_W];
            end
        end
    end

    // Routing uses the current (pre-switch) select/state; SHOW swallows presses.
    always_comb begin
        o_game_btn = '0;
        for (int g = 0; g < int'(NUM_GAMES); g++) begin
            if (r_state == ST_RUN && r_select == SEL_W'(g)) begin
                o_game_btn[g*NUM_BTNS +: NUM_BTNS] = i_btn_pulse;
            end
        end
    end

    assign o_game_enter    = r_enter;
    assign o_select        = r_select;
    assign o_show_active   = (r_state == ST_SHOW);
    assign o_display_value = r_display;

endmodule

// File: tb/tb_game_switcher.sv
module tb_game_switcher;

    localparam int unsigned NG = 3;
    localparam int unsigned NB = 7;
    localparam int unsigned VW = 4;
    localparam int unsigned SC = 4;
    localparam int unsigned SW = 2;

    logic             clk;
    logic             rst_n;
    logic             next_pulse;
    logic             prev_pulse;
    logic [NB-1:0]    btn_pulse;
    logic [NG*VW-1:0] game_value;
    logic [NG*NB-1:0] game_btn;
    logic [NG-1:0]    game_enter;
    logic [SW-1:0]    sel;
    logic             show_active;
    logic [VW-1:0]    display_value;

    int checks = 0;
    int errors = 0;

    game_switcher #(
        .NUM_GAMES  (NG),
        .NUM_BTNS   (NB),
        .VAL_W      (VW),
        .SHOW_CYCLES(SC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_next_pulse   (next_pulse),
        .i_prev_pulse   (prev_pulse),
        .i_btn_pulse    (btn_pulse),
        .i_game_value   (game_value),
        .o_game_btn     (game_btn),
        .o_game_enter   (game_enter),
        .o_select       (sel),
        .o_show_active  (show_active),
        .o_display_value(display_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, want finish)");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_run();
        int n;
        n = 0;
        while (show_active === 1'b1 && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (show_active !== 1'b0) begin
            errors++;
            $display("FAIL wait_run: show_active got %b want 0 within 10 cycles", show_active);
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        next_pulse = 1'b0;
        prev_pulse = 1'b0;
        btn_pulse  = '0;
        game_value = 12'h965;  // slot0=5, slot1=6, slot2=9
        #12;
        checks++;
        if (display_value !== 4'd12 || sel !== 2'd0 || show_active !== 1'b0 ||
            game_enter !== 3'b000 || game_btn !== '0) begin
            errors++;
            $display("FAIL reset_values: disp=%0d sel=%0d show=%b enter=%b btn=%h want 12 0 0 000 0",
                     display_value, sel, show_active, game_enter, game_btn);
        end
        tick();
        rst_n = 1'b1;
        checks++;
        if (display_value !== 4'd12) begin
            errors++;
            $display("FAIL first_cycle_blank: disp got %0d want 12", display_value);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (display_value !== 4'd5 || sel !== 2'd0 || show_active !== 1'b0) begin
                errors++;
                $display("FAIL idle_slot0: disp=%0d sel=%0d show=%b want 5 0 0",
                         display_value, sel, show_active);
            end
        end
    endtask

    task automatic test_next_wrap();
        int exp_seq [5] = '{1, 2, 0, 1, 2};
        for (int i = 0; i < 5; i++) begin
            next_pulse = 1'b1;
            tick();
            next_pulse = 1'b0;
            checks++;
            if (sel !== SW'(exp_seq[i]) || game_enter !== (3'b001 << exp_seq[i]) ||
                show_active !== 1'b1) begin
                errors++;
                $display("FAIL next_step%0d: sel=%0d enter=%b show=%b want %0d %b 1", i, sel,
                         game_enter, show_active, exp_seq[i], 3'b001 << exp_seq[i]);
            end
            tick();
            checks++;
            if (game_enter !== 3'b000 || display_value !== VW'(exp_seq[i])) begin
                errors++;
                $display("FAIL next_after%0d: enter=%b disp=%0d want 000 %0d", i, game_enter,
                         display_value, exp_seq[i]);
            end
        end
        wait_run();
    endtask

    task automatic test_prev_and_both();
        next_pulse = 1'b1;
        tick();
        next_pulse = 1'b0;
        wait_run();
        prev_pulse = 1'b1;
        tick();
        prev_pulse = 1'b0;
        checks++;
        if (sel !== 2'd2 || game_enter !== 3'b100) begin
            errors++;
            $display("FAIL prev_wrap: sel=%0d enter=%b want 2 100", sel, game_enter);
        end
        wait_run();
        next_pulse = 1'b1;
        prev_pulse = 1'b1;
        tick();
        next_pulse = 1'b0;
        prev_pulse = 1'b0;
        checks++;
        if (sel !== 2'd2 || game_enter !== 3'b000 || show_active !== 1'b0) begin
            errors++;
            $display("FAIL both_pulses: sel=%0d enter=%b show=%b want 2 000 0", sel,
                     game_enter, show_active);
        end
    endtask

    task automatic test_show_swallow();
        next_pulse = 1'b1;
        tick();  // select 2 -> 0
        next_pulse = 1'b0;
        btn_pulse  = 7'h01;
        checks++;
        if (game_btn !== '0) begin
            errors++;
            $display("FAIL show_btn_gated: game_btn got %h want 0", game_btn);
        end
        tick();
        btn_pulse = '0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (show_active !== 1'b1 || display_value !== 4'd0) begin
                errors++;
                $display("FAIL show_banner%0d: show=%b disp=%0d want 1 0", k, show_active,
                         display_value);
            end
            tick();
        end
        checks++;
        if (show_active !== 1'b0 || display_value !== 4'd0) begin
            errors++;
            $display("FAIL show_end: show=%b disp=%0d want 0 0", show_active, display_value);
        end
        tick();
        checks++;
        if (display_value !== 4'd5 || game_btn !== '0) begin
            errors++;
            $display("FAIL run_resume: disp=%0d btn=%h want 5 0", display_value, game_btn);
        end
        btn_pulse = 7'h01;
        #1;
        checks++;
        if (game_btn !== 21'h000001) begin
            errors++;
            $display("FAIL run_btn_slot0: game_btn got %h want 000001", game_btn);
        end
        // Switch sampled in the same cycle: routing still uses the old RUN/slot 0.
        btn_pulse  = 7'h40;
        next_pulse = 1'b1;
        #1;
        checks++;
        if (game_btn !== 21'h000040) begin
            errors++;
            $display("FAIL switch_cycle_route: game_btn got %h want 000040", game_btn);
        end
        tick();
        next_pulse = 1'b0;
        checks++;
        if (game_btn !== '0 || sel !== 2'd1) begin
            errors++;
            $display("FAIL post_switch_gate: btn=%h sel=%0d want 0 1", game_btn, sel);
        end
        btn_pulse = '0;
        wait_run();
        btn_pulse = 7'h22;
        #1;
        checks++;
        if (game_btn !== 21'h001100) begin
            errors++;
            $display("FAIL run_btn_slot1: game_btn got %h want 001100", game_btn);
        end
        btn_pulse = '0;
    endtask

    task automatic test_retrigger();
        next_pulse = 1'b1;
        tick();  // E0: 1 -> 2
        next_pulse = 1'b0;
        tick();  // E1
        next_pulse = 1'b1;
        tick();  // E2: 2 -> 0, timer reloads
        next_pulse = 1'b0;
        checks++;
        if (sel !== 2'd0 || game_enter !== 3'b001) begin
            errors++;
            $display("FAIL retrig_switch: sel=%0d enter=%b want 0 001", sel, game_enter);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (show_active !== 1'b1) begin
                errors++;
                $display("FAIL retrig_hold%0d: show got %b want 1", k, show_active);
            end
        end
        tick();
        checks++;
        if (show_active !== 1'b0) begin
            errors++;
            $display("FAIL retrig_run: show got %b want 0", show_active);
        end
    endtask

    task automatic test_reset_mid_show();
        next_pulse = 1'b1;
        tick();
        next_pulse = 1'b0;
        checks++;
        if (game_enter !== 3'b010 || show_active !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_enter: enter=%b show=%b want 010 1", game_enter, show_active);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (game_enter !== 3'b000 || sel !== 2'd0 || show_active !== 1'b0 ||
            display_value !== 4'd12) begin
            errors++;
            $display("FAIL async_reset: enter=%b sel=%0d show=%b disp=%0d want 000 0 0 12",
                     game_enter, sel, show_active, display_value);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (sel !== 2'd0 || show_active !== 1'b0 || display_value !== 4'd5 ||
            game_enter !== 3'b000) begin
            errors++;
            $display("FAIL post_reset_run: sel=%0d show=%b disp=%0d enter=%b want 0 0 5 000",
                     sel, show_active, display_value, game_enter);
        end
    endtask

    initial begin
        test_reset();
        test_next_wrap();
        test_prev_and_both();
        test_show_swallow();
        test_retrigger();
        test_reset_mid_show();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
